// File: rtl/tug_match_controller_if.sv
// Key/light inputs and score/status outputs of the match controller.
// The slave modport is the controller's view.
interface tug_match_controller_if;
  logic       L;
  logic       R;
  logic       MostLeft;
  logic       MostRight;
  logic       playfield_clear;
  logic       in_play;
  logic [6:0] hex_left;
  logic [6:0] hex_right;
  logic [6:0] winner;

  modport master (
    output L, R, MostLeft, MostRight,
    input  playfield_clear, in_play, hex_left, hex_right, winner
  );

  modport slave (
    input  L, R, MostLeft, MostRight,
    output playfield_clear, in_play, hex_left, hex_right, winner
  );
endinterface

// File: rtl/tug_match_controller.sv
// Tug-of-war match sequencer: scores points, freezes the board after each point,
// clears the playfield between rounds and latches the match winner.
module tug_match_controller #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input logic                  Clock,
  input logic                  Reset,
  tug_match_controller_if.slave bus
);

  localparam logic [3:0] WinS     = 4'(WIN_SCORE);
  localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);
  localparam logic [6:0] NoWinner = 7'b1111111;
  localparam logic [6:0] LeftWon  = 7'b1111001;
  localparam logic [6:0] RightWon = 7'b0100100;

  typedef enum logic [1:0] {
    StServe = 2'd0,
    StPlay  = 2'd1,
    StPoint = 2'd2,
    StOver  = 2'd3
  } state_e;

  state_e     fsm_q;
  logic [3:0] score_l_q;
  logic [3:0] score_r_q;
  logic [7:0] hold_cnt_q;
  logic [6:0] win_q;

  // Win rule needs exactly one key, so L and R together never score.
  logic left_pt, right_pt;
  assign left_pt  = bus.MostLeft  && bus.L && !bus.R;
  assign right_pt = bus.MostRight && bus.R && !bus.L;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      fsm_q      <= StServe;
      score_l_q  <= 4'd0;
      score_r_q  <= 4'd0;
      hold_cnt_q <= 8'd0;
      win_q      <= NoWinner;
    end else begin
      case (fsm_q)
        StServe: fsm_q <= StPlay;
        StPlay: begin
          if (left_pt) begin
            score_l_q  <= score_l_q + 4'd1;
            hold_cnt_q <= HoldLoad;
            fsm_q      <= StPoint;
          end else if (right_pt) begin
            score_r_q  <= score_r_q + 4'd1;
            hold_cnt_q <= HoldLoad;
            fsm_q      <= StPoint;
          end
        end
        StPoint: begin
          if (hold_cnt_q != 8'd0) begin
            hold_cnt_q <= hold_cnt_q - 8'd1;
          end else if (score_l_q == WinS || score_r_q == WinS) begin
            fsm_q <= StOver;
            win_q <= (score_l_q == WinS) ? LeftWon : RightWon;
          end else begin
            fsm_q <= StServe;
          end
        end
        StOver:  fsm_q <= StOver;
        default: fsm_q <= StServe;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign bus.playfield_clear = (fsm_q == StServe);
  assign bus.in_play         = (fsm_q == StPlay);
  assign bus.hex_left        = seg7(score_l_q);
  assign bus.hex_right       = seg7(score_r_q);
  assign bus.winner          = win_q;

endmodule
